puf_race_collector: RTL
=======================

Name: puf_race_collector

Overview:
- Downstream consumer of two post-mux edge counters (A and B) in the delay-based PUF datapath.
- For each challenge index, the block:
  - clears both counters,
  - enables them,
  - waits for the first one to raise finished,
  - records the winner as one response bit.
- Bits are shifted into a RESP_BITS-wide word, then handed to the serial output stage over a valid/ready handshake.

Parameters:
- N, 23: width of the counter values; must match the upstream counters.
- RESP_BITS, 32: number of response bits per collection, i.e. the number of challenges.
- CLR_CYCLES, 2: cycles cnt_reset is held high before each race; minimum 1.
- TIMEOUT, 2**24: maximum RACE cycles before the race is aborted.

Ports:
- clk, in, 1: system clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-low reset.
- start, in, 1: begins a collection; sampled in IDLE only.
- finished_a, in, 1: finished flag from counter A.
- finished_b, in, 1: finished flag from counter B.
- cnt_reset, out, 1: active-high reset to both counters.
- cnt_enable, out, 1: count enable to both counters.
- challenge, out, $clog2(RESP_BITS): current challenge index, drives the mux select.
- resp_data, out, RESP_BITS: collected response word.
- resp_valid, out, 1: resp_data is valid.
- resp_ready, in, 1: downstream accepts resp_data.
- busy, out, 1: high in any state other than IDLE.
- tie_flag, out, 1: sticky; at least one race in this word ended in a tie.
- timeout_flag, out, 1: sticky; at least one race in this word timed out.

Behaviour:
- Reset (reset==0 at a clk edge), all of the following hold on the next cycle:
  - state=IDLE;
  - cnt_reset=1, so the counters are held cleared;
  - cnt_enable=0, challenge=0, resp_data=0, resp_valid=0, busy=0;
  - tie_flag=0, timeout_flag=0;
  - internal cycle counters = 0.
  - Reset mid-operation aborts the collection immediately; the partial word is discarded.
- IDLE:
  - cnt_reset=1, cnt_enable=0.
  - start=1 → go to CLEAR. On the same edge: challenge←0, resp_data←0, tie_flag←0, timeout_flag←0.
- CLEAR:
  - cnt_reset=1, cnt_enable=0.
  - Stay exactly CLR_CYCLES cycles, then go to RACE.
- RACE:
  - cnt_reset=0, cnt_enable=1; the timeout counter increments each cycle.
  - Decision on the first cycle where finished_a|finished_b=1 or the timeout counter reaches TIMEOUT-1:
    - a only → bit=1;
    - b only → bit=0;
    - both in the same cycle → bit=0 and tie_flag←1;
    - timeout with neither finished → bit=0 and timeout_flag←1;
    - finished and timeout in the same cycle → the finished rule wins; timeout_flag is not set.
  - Bit placement: resp_data←{resp_data[RESP_BITS-2:0], bit}. Challenge 0 ends up in the MSB.
  - Next state: go to DONE if challenge==RESP_BITS-1; otherwise challenge←challenge+1 and go to CLEAR.
  - The timeout counter clears on leaving RACE.
- DONE:
  - cnt_reset=1, cnt_enable=0, resp_valid=1.
  - resp_data, tie_flag and timeout_flag are frozen.
  - Go to IDLE on resp_valid&resp_ready; resp_valid=0 on the next cycle.
  - tie_flag and timeout_flag persist until the next start.
- start is ignored outside IDLE.
- Latency: the first race begins CLR_CYCLES+1 cycles after start is sampled. A race resolving in k enabled cycles adds CLR_CYCLES+k cycles per bit.
- finished is sampled exactly as presented. The upstream counter keeps finished high until its own reset, so only the first qualifying cycle counts.
- challenge is stable throughout CLEAR and RACE of a given bit.

Test Plan:
- Single win A: RESP_BITS=4, N=6, CLR_CYCLES=2; finished_a asserted 5 cycles into every RACE → resp_data=4'b1111, resp_valid=1, tie_flag=0, timeout_flag=0; challenge sequence 0,1,2,3.
- Mixed pattern: RESP_BITS=4; per-race winners A,B,B,A → resp_data=4'b1001. Check cnt_reset high for exactly 2 cycles before each RACE and cnt_enable high only during RACE.
- Tie and timeout:
  - Race 1: finished_a and finished_b rise in the same cycle.
  - Race 2: TIMEOUT=16 and neither finishes.
  - Races 3 and 4: won by A.
  - Required: resp_data=4'b0011, tie_flag=1, timeout_flag=1; race 2 lasts exactly 16 RACE cycles.
- Backpressure: hold resp_ready=0 for 10 cycles after DONE → resp_valid stays 1 and resp_data is unchanged; start pulses during DONE are ignored. Raise resp_ready → resp_valid=0 and busy=0 next cycle.
- Reset mid-race: drive reset=0 during race 2 → next cycle all outputs are at their reset values (cnt_reset=1). A new start yields a fresh, complete 4-bit word.
- Back-to-back: assert start in the same cycle resp_valid&resp_ready completes → start is ignored (not in IDLE). Assert start on the following cycle → it is accepted; flags cleared, challenge=0.

Source files
------------

// File: rtl/puf_race_collector_if.sv
// Response handoff bundle between the PUF race collector and the serial output stage.
interface puf_race_collector_if #(
  parameter int RESP_BITS = 32
);
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 tie_flag;
  logic                 timeout_flag;

  modport master (
    output resp_data, resp_valid, tie_flag, timeout_flag,
    input  resp_ready
  );

  modport slave (
    input  resp_data, resp_valid, tie_flag, timeout_flag,
    output resp_ready
  );
endinterface

// File: rtl/puf_race_collector.sv
// Runs one counter race per challenge index and shifts each winner into a response word
// that is handed downstream over a valid/ready handshake.
module puf_race_collector #(
  parameter int N          = 23,
  parameter int RESP_BITS  = 32,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 2**24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         finished_a,
  input  logic                         finished_b,
  output logic                         cnt_reset,
  output logic                         cnt_enable,
  output logic [$clog2(RESP_BITS)-1:0] challenge,
  output logic                         busy,
  puf_race_collector_if.master         resp_if
);
  localparam int CW = $clog2(RESP_BITS);
  localparam int TW = $clog2(TIMEOUT);
  localparam int KW = $clog2(CLR_CYCLES + 1);
  localparam logic [CW-1:0] CHAL_LAST = CW'(RESP_BITS - 1);
  localparam logic [TW-1:0] RACE_LAST = TW'(TIMEOUT - 1);
  localparam logic [KW-1:0] CLR_LAST  = KW'(CLR_CYCLES - 1);

  if (N < 1 || RESP_BITS < 2 || CLR_CYCLES < 1 || TIMEOUT < 2) begin : g_param_check
    $error("puf_race_collector: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RACE  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         chal_q, chal_d;
  logic [RESP_BITS-1:0]  data_q, data_d;
  logic                  tie_q, tie_d;
  logic                  tout_q, tout_d;
  logic [KW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [TW-1:0]         race_cnt_q, race_cnt_d;
  logic                  cnt_reset_q, cnt_reset_d;
  logic                  cnt_enable_q, cnt_enable_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  // Next-state and datapath; counter controls are derived from the next state so they stay registered.
  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    data_d     = data_q;
    tie_d      = tie_q;
    tout_d     = tout_q;
    clr_cnt_d  = clr_cnt_q;
    race_cnt_d = race_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          chal_d    = '0;
          data_d    = '0;
          tie_d     = 1'b0;
          tout_d    = 1'b0;
          clr_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = S_RACE;
          clr_cnt_d  = '0;
          race_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + KW'(1);
        end
      end
      S_RACE: begin
        // A finish in the timeout cycle still counts as a finish, never as a timeout.
        if (finished_a || finished_b || (race_cnt_q == RACE_LAST)) begin
          data_d     = {data_q[RESP_BITS-2:0], finished_a & ~finished_b};
          race_cnt_d = '0;
          if (finished_a && finished_b) begin
            tie_d = 1'b1;
          end else begin
            tie_d = tie_q;
          end
          if (!finished_a && !finished_b) begin
            tout_d = 1'b1;
          end else begin
            tout_d = tout_q;
          end
          if (chal_q == CHAL_LAST) begin
            state_d = S_DONE;
          end else begin
            chal_d    = chal_q + CW'(1);
            clr_cnt_d = '0;
            state_d   = S_CLEAR;
          end
        end else begin
          race_cnt_d = race_cnt_q + TW'(1);
        end
      end
      S_DONE: begin
        if (resp_if.resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cnt_reset_d  = (state_d != S_RACE);
    cnt_enable_d = (state_d == S_RACE);
    valid_d      = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      chal_q       <= '0;
      data_q       <= '0;
      tie_q        <= 1'b0;
      tout_q       <= 1'b0;
      clr_cnt_q    <= '0;
      race_cnt_q   <= '0;
      cnt_reset_q  <= 1'b1;
      cnt_enable_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chal_q       <= chal_d;
      data_q       <= data_d;
      tie_q        <= tie_d;
      tout_q       <= tout_d;
      clr_cnt_q    <= clr_cnt_d;
      race_cnt_q   <= race_cnt_d;
      cnt_reset_q  <= cnt_reset_d;
      cnt_enable_q <= cnt_enable_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign cnt_reset            = cnt_reset_q;
  assign cnt_enable           = cnt_enable_q;
  assign challenge            = chal_q;
  assign busy                 = busy_q;
  assign resp_if.resp_data    = data_q;
  assign resp_if.resp_valid   = valid_q;
  assign resp_if.tie_flag     = tie_q;
  assign resp_if.timeout_flag = tout_q;
endmodule
